// File: rtl/bsg_wormhole_rr_static_merge_pkg.sv
// Shared wormhole definitions: default widths, header layout and packet-tracker states.
package bsg_wormhole_rr_static_merge_pkg;

    localparam int wh_flit_width_gp = 32;
    localparam int wh_len_width_gp  = 4;
    localparam int wh_cord_width_gp = 8;

    // Header occupies the low bits of a flit: cord first, length directly above it.
    typedef struct packed {
        logic [wh_len_width_gp-1:0]  len;
        logic [wh_cord_width_gp-1:0] cord;
    } wh_header_s;

    typedef enum logic {
        eHeader = 1'b0,
        eBody   = 1'b1
    } wh_state_e;

endpackage

// File: rtl/bsg_wormhole_packet_tracker.sv
// Tracks header/body position within a wormhole packet; strobes on the last flit.
module bsg_wormhole_packet_tracker
    import bsg_wormhole_rr_static_merge_pkg::*;
#(
    parameter int len_width_p = wh_len_width_gp
)
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   xfer_i,
    input  logic [len_width_p-1:0] len_i,
    output logic                   in_packet_o,
    output logic                   last_flit_o
);

    wh_state_e              state_q;
    logic [len_width_p-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eHeader;
            cnt_q   <= '0;
        end else if (xfer_i) begin
            case (state_q)
                eHeader: begin
                    if (len_i != '0) begin
                        cnt_q   <= len_i;
                        state_q <= eBody;
                    end
                end
                eBody: begin
                    cnt_q <= cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_q <= eHeader;
                    end
                end
                default: state_q <= eHeader;
            endcase
        end
    end

    assign in_packet_o = (state_q == eBody);

    // A zero-length header is itself the last flit of its packet.
    assign last_flit_o = xfer_i & ((state_q == eHeader) ? (len_i == '0)
                                                        : (cnt_q == len_width_p'(1)));

endmodule

// File: rtl/bsg_wormhole_rr_static_merge.sv
// Re-forms one wormhole flit stream from packets striped round-robin across num_in_p links.
module bsg_wormhole_rr_static_merge
    import bsg_wormhole_rr_static_merge_pkg::*;
#(
    parameter int flit_width_p = wh_flit_width_gp,
    parameter int len_width_p  = wh_len_width_gp,
    parameter int cord_width_p = wh_cord_width_gp,
    parameter int num_in_p     = 2
)
(
    input  logic                                   clk_i,
    input  logic                                   reset_i,

    input  logic [num_in_p-1:0]                    in_v_i,
    input  logic [num_in_p-1:0][flit_width_p-1:0]  in_data_i,
    output logic [num_in_p-1:0]                    in_ready_and_o,

    output logic                                   v_o,
    output logic [flit_width_p-1:0]                data_o,
    input  logic                                   ready_and_i,

    output logic [$clog2(num_in_p)-1:0]            ptr_o,
    output logic                                   in_packet_o
);

    localparam int ptr_width_lp = $clog2(num_in_p);

    logic [ptr_width_lp-1:0] ptr_q, ptr_d;
    logic                    sel_v;
    logic [flit_width_p-1:0] sel_data;
    logic                    xfer;
    logic                    last_flit;
    logic                    tracker_in_packet;

    assign sel_v    = in_v_i[ptr_q];
    assign sel_data = in_data_i[ptr_q];

    assign v_o    = sel_v & ~reset_i;
    assign data_o = sel_data;
    assign xfer   = v_o & ready_and_i;

    // Only the selected link ever sees ready, so other links hold their flits.
    always_comb begin
        in_ready_and_o = '0;
        if (!reset_i) begin
            in_ready_and_o[ptr_q] = ready_and_i;
        end
    end

    bsg_wormhole_packet_tracker #(
        .len_width_p(len_width_p)
    ) tracker (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .xfer_i      (xfer),
        .len_i       (sel_data[cord_width_p +: len_width_p]),
        .in_packet_o (tracker_in_packet),
        .last_flit_o (last_flit)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (last_flit) begin
            ptr_d = (ptr_q == ptr_width_lp'(num_in_p - 1)) ? '0 : ptr_q + ptr_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o       = reset_i ? '0 : ptr_q;
    assign in_packet_o = tracker_in_packet & ~reset_i;

endmodule
